// File: rtl/quantize_pipe.sv
// ---------------------------------------------------------------------------
// quantize_pipe
//
// Two-stage quantizer for ARRAY_SIZE signed accumulator lanes.
//   S1: per-lane arithmetic right shift with optional round-half-up,
//       computed one bit wider than the input lane so the rounding add
//       can never overflow.
//   S2: per-lane saturation to the signed OUTPUT_DATA_WIDTH range, with a
//       per-lane clip flag and a saturating count of clipped output beats.
//
// Ports
//   clk            clock, all state changes on its rising edge
//   rst            asynchronous, active-high reset
//   in_valid       input beat present (ori_data, shift_amt, round_en)
//   in_ready       block accepts the input beat this cycle
//   ori_data       ARRAY_SIZE signed lanes of ORI_WIDTH bits, lane i at
//                  [i*ORI_WIDTH +: ORI_WIDTH]
//   shift_amt      right-shift amount, clamped to ORI_WIDTH-1, per beat
//   round_en       1 = round half up, 0 = truncate toward -inf, per beat
//   out_valid      output beat present
//   out_ready      downstream accepts the output beat
//   quantized_data ARRAY_SIZE signed lanes of OUTPUT_DATA_WIDTH bits
//   sat_flags      bit i set when lane i of the output beat was clipped
//   sat_clr        synchronous clear of sat_count (wins over increment)
//   sat_count      number of transferred output beats with any clipped lane
//
// Handshake (both ports): a beat moves when valid & ready are both high in
// the same cycle. Valid never depends on ready; once out_valid is raised the
// output beat is held unchanged until it transfers. Each stage advances when
// the stage after it is empty or draining:
//   adv2 = !out_valid | out_ready, adv1 = !s1_valid | adv2, in_ready = adv1
// ---------------------------------------------------------------------------
module quantize_pipe #(
  parameter int ARRAY_SIZE        = 32,
  parameter int DATA_WIDTH        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int SHIFT_WIDTH       = 5,
  parameter int CNT_WIDTH         = 16,
  localparam int ORI_WIDTH        = 2*DATA_WIDTH+5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ARRAY_SIZE*ORI_WIDTH-1:0]       ori_data,
  input  logic [SHIFT_WIDTH-1:0]                shift_amt,
  input  logic                                  round_en,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
  output logic [ARRAY_SIZE-1:0]                 sat_flags,
  input  logic                                  sat_clr,
  output logic [CNT_WIDTH-1:0]                  sat_count
);

  // S1 lanes are one bit wider than the input so ori + 2^(s-1) fits.
  localparam int S1W = ORI_WIDTH + 1;
  localparam int OW  = OUTPUT_DATA_WIDTH;
  localparam logic [31:0] MAX_SHIFT = 32'(ORI_WIDTH - 1);
  localparam logic signed [S1W-1:0] OMAX = S1W'((64'sd1 <<< (OW-1)) - 64'sd1);
  localparam logic signed [S1W-1:0] OMIN = ~OMAX;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [S1W-1:0] ONE = S1W'(1);

  // Stage registers
  logic                  s1_valid_q;
  logic signed [S1W-1:0] s1_data_q [ARRAY_SIZE];
  logic signed [S1W-1:0] s1_data_d [ARRAY_SIZE];

  logic                              out_valid_q;
  logic [ARRAY_SIZE*OW-1:0]          out_data_q;
  logic [ARRAY_SIZE*OW-1:0]          out_data_d;
  logic [ARRAY_SIZE-1:0]             sat_flags_q;
  logic [ARRAY_SIZE-1:0]             sat_flags_d;
  logic [CNT_WIDTH-1:0]              sat_count_q;
  logic [CNT_WIDTH-1:0]              sat_count_d;

  logic adv1;
  logic adv2;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // Shift amount shared by all lanes of the beat. Amounts past the lane
  // width would only replicate the sign bit, so they clamp to ORI_WIDTH-1.
  logic [31:0]           s_eff;
  logic signed [S1W-1:0] rnd_add;

  always_comb begin
    s_eff = 32'(shift_amt);
    if (s_eff > MAX_SHIFT) begin
      s_eff = MAX_SHIFT;
    end
    rnd_add = '0;
    if (round_en && (s_eff != 32'd0)) begin
      rnd_add = ONE << (s_eff - 32'd1);
    end
  end

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    logic [ORI_WIDTH-1:0]  lane_raw;
    logic signed [S1W-1:0] lane_sum;
    logic signed [S1W-1:0] lane_s1;
    logic                  clip_hi;
    logic                  clip_lo;

    // S1: sign-extend, add rounding bias, arithmetic shift (floors).
    assign lane_raw      = ori_data[g*ORI_WIDTH +: ORI_WIDTH];
    assign lane_sum      = $signed({lane_raw[ORI_WIDTH-1], lane_raw}) + rnd_add;
    assign s1_data_d[g]  = lane_sum >>> s_eff;

    // S2: values equal to a limit are in range and pass unflagged.
    assign lane_s1 = s1_data_q[g];
    assign clip_hi = lane_s1 > OMAX;
    assign clip_lo = lane_s1 < OMIN;
    assign sat_flags_d[g] = clip_hi | clip_lo;
    assign out_data_d[g*OW +: OW] = clip_hi ? OMAX[OW-1:0] :
                                    clip_lo ? OMIN[OW-1:0] :
                                              lane_s1[OW-1:0];
  end

  // S1 register: loads a new beat (or a bubble) whenever it can advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        s1_data_q[i] <= '0;
      end
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < ARRAY_SIZE; i++) begin
          s1_data_q[i] <= s1_data_d[i];
        end
      end
    end
  end

  // S2 register: data only changes when the slot is empty or draining,
  // which keeps the output stable during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_flags_q <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q  <= out_data_d;
        sat_flags_q <= sat_flags_d;
      end
    end
  end

  // Clipped-beat counter: clear wins, otherwise count transfers, no wrap.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_valid_q && out_ready && (|sat_flags_q) &&
                 (sat_count_q != CNT_MAX)) begin
      sat_count_d = sat_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign quantized_data = out_data_q;
  assign sat_flags      = sat_flags_q;
  assign sat_count      = sat_count_q;

endmodule

// File: doc/quantize_pipe.md
QUANTIZE_PIPE -- requirements
Module: quantize_pipe

Interface
REQ-001 Parameter ARRAY_SIZE, default 32, SHALL set the number of lanes.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the operand width; ORI_WIDTH = 2*DATA_WIDTH+5 (default 21) SHALL be the input lane width.
REQ-003 Parameter OUTPUT_DATA_WIDTH, default 16, SHALL set the output lane width (signed).
REQ-004 Parameter SHIFT_WIDTH, default 5, SHALL set the width of shift_amt.
REQ-005 Parameter CNT_WIDTH, default 16, SHALL set the width of sat_count.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 in_valid  input  1  ori_data, shift_amt and round_en are valid.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 ori_data  input  ARRAY_SIZE*ORI_WIDTH  signed lanes; lane i at bits [i*ORI_WIDTH +: ORI_WIDTH].
REQ-012 shift_amt  input  SHIFT_WIDTH  arithmetic right-shift amount, sampled per beat.
REQ-013 round_en  input  1  1 = round half up; 0 = truncate toward minus infinity. Sampled per beat.
REQ-014 out_valid  output  1  quantized_data and sat_flags are valid.
REQ-015 out_ready  input  1  downstream accepts the beat.
REQ-016 quantized_data  output  ARRAY_SIZE*OUTPUT_DATA_WIDTH  signed result lanes, same lane order as ori_data.
REQ-017 sat_flags  output  ARRAY_SIZE  bit i = 1 when lane i of the current output beat was clipped.
REQ-018 sat_clr  input  1  synchronous clear of sat_count.
REQ-019 sat_count  output  CNT_WIDTH  number of output beats with any saturated lane.

Function
REQ-020 The pipeline SHALL have two register stages: S1 (shift/round) and S2 (saturate/output). A beat accepted in cycle N SHALL appear on out_valid in cycle N+2 when there is no stall.
REQ-021 The S1 result per lane SHALL be (ori + R) >>> s, computed at ORI_WIDTH+1 bits with no overflow. s = min(shift_amt, ORI_WIDTH-1). R = 2^(s-1) when round_en=1 and s>0; otherwise R = 0.
REQ-022 S2 SHALL clip each lane to the range [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1] (defaults -32768/32767). Clipping sets the lane's sat_flags bit; an in-range value passes through exactly with its flag at 0.
REQ-023 A value exactly equal to a limit SHALL pass through with its flag at 0.
REQ-024 Handshake: adv2 = !out_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1. in_ready is combinational from out_ready.
REQ-025 A beat transfers on input when in_valid & in_ready, and on output when out_valid & out_ready.
REQ-026 While out_valid=1 and out_ready=0, quantized_data, sat_flags and out_valid SHALL hold stable.
REQ-027 Bubbles SHALL collapse: an empty S1 or S2 SHALL accept new data even while out_ready=0. No beat SHALL be dropped or duplicated.
REQ-028 Simultaneous accept and emit SHALL sustain one beat per cycle.
REQ-029 sat_count SHALL increment by 1 on each output transfer where |sat_flags != 0, and SHALL saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-030 sat_clr SHALL take priority over increment: sat_count becomes 0 on the next edge, even if an increment is due that cycle.
REQ-031 shift_amt and round_en SHALL travel with their beat. A change between beats SHALL affect only later beats.

Reset
REQ-032 Asserting rst SHALL immediately clear s1_valid, out_valid and sat_count to 0, and set quantized_data and sat_flags to 0.
REQ-033 In-flight beats SHALL be discarded on reset. After rst deasserts, in_ready SHALL be 1 in the first cycle.
REQ-034 Data registers SHALL reset to 0 so outputs are never X after reset.

Verification
REQ-035 Lane0 = 1000, shift 2, round 0 -> lane0 = 250, flag 0, two cycles after acceptance.
REQ-036 Lane0 = 5, shift 1: round 1 -> 3; round 0 -> 2. Lane0 = -5, shift 1: round 1 -> -2; round 0 -> -3.
REQ-037 Lane0 = 100000, shift 0 -> 32767 with flag 1. Lane1 = -100000 -> -32768 with flag 1. Lane2 = 32767 -> 32767 with flag 0. sat_count increments by exactly 1.
REQ-038 Stream 8 beats while out_ready toggles randomly -> all 8 beats emitted in order, unchanged during stalls, in_ready=0 only when both stages are full and out_ready=0.
REQ-039 Hold sat_count at max, then send a saturating beat -> count stays at max. Pulse sat_clr while a saturating beat transfers -> count = 0.
REQ-040 Assert rst mid-stream with 2 beats in flight -> out_valid=0 at once with no later emission of those beats. shift_amt = 31 with ORI_WIDTH=21 -> behaves as shift 20.
